nod_pipe: RTL

NOD_PIPE -- requirements
Module: nod_pipe

---
 rtl/nod_pipe.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/nod_pipe.sv
// -----------------------------------------------------------------------------
// nod_pipe -- nearest-power-of-two rounding pipeline
//
// Purpose:
//   For each accepted unsigned operand in_a, produce the nearest power of two
//   as a one-hot vector, the index of its set bit, and the exact signed
//   residual (in_a - onehot). Midpoints round up (3->4, 6->8). A zero operand
//   yields all-zero results with out_zero set.
//
//   Two register stages with valid/ready flow control:
//     S1: operand and its leading-one position
//     S2: rounded one-hot, index, residual, zero flag (drives the outputs)
//   Throughput is one operand per cycle. Latency is 2 cycles with out_ready
//   held high. A stalled stage holds its contents unchanged.
//
// Configuration macro:
//   NOD_OVF_EN  defined   -> rounding past bit W-1 yields out_onehot[W]=1,
//                            out_idx=W.
//               undefined -> result saturates at bit W-1, out_onehot[W]=0;
//                            residual stays exact against the saturated value.
//
// Parameters:
//   W   operand width (3..32), default 16
//   IW  width of out_idx, default $clog2(W+1)
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     in_a holds a valid operand
//   in_ready   out  1     operand accepted this cycle when in_valid is high
//   in_a       in   W     unsigned operand
//   out_valid  out  1     output fields hold a valid result
//   out_ready  in   1     consumer takes the result this cycle
//   out_onehot out  W+1   one-hot rounded power of two (0 for zero operand)
//   out_idx    out  IW    position of the set bit (0 for zero operand)
//   out_res    out  W+2   two's complement residual in_a - out_onehot
//   out_zero   out  1     operand was zero
// -----------------------------------------------------------------------------
module nod_pipe #(
  parameter int unsigned W  = 16,
  parameter int unsigned IW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    out_onehot,
  output logic [IW-1:0] out_idx,
  output logic [W+1:0]  out_res,
  output logic          out_zero
);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic          r_s1_valid;
  logic [W-1:0]  r_s1_a;
  logic [IW-1:0] r_s1_lead;

  logic          r_s2_valid;
  logic [W:0]    r_s2_onehot;
  logic [IW-1:0] r_s2_idx;
  logic [W+1:0]  r_s2_res;
  logic          r_s2_zero;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic w_s1_adv;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  assign w_s1_adv = !r_s2_valid || out_ready;
  // S1 can take a new operand when empty or when its content moves on.
  assign in_ready = !r_s1_valid || w_s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: leading-one position of the incoming operand.
  // Highest set bit wins because later iterations overwrite earlier ones.
  // A zero operand leaves position 0; S2 detects zero from the operand itself.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] w_lead;

  always_comb begin
    w_lead = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (in_a[i]) begin
        w_lead = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_lead  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= in_a;
        r_s1_lead <= w_lead;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: rounding decision, one-hot, index, residual
  // ---------------------------------------------------------------------------
  logic          w_s1_zero;
  logic          w_round_up;
  logic [IW-1:0] w_idx;
  logic [W:0]    w_onehot;
  logic [W+1:0]  w_res;

  assign w_s1_zero = (r_s1_a == '0);

  // The operand lies between 2^p and 2^(p+1); its midpoint is 2^p + 2^(p-1).
  // The bit just below the leading one is set exactly when the operand is at
  // or above that midpoint, so it alone decides the round-up (ties go up).
  // p = 0 has no bit below and never rounds up.
  always_comb begin
    w_round_up = 1'b0;
    for (int unsigned i = 1; i < W; i++) begin
      if (r_s1_lead == IW'(i)) begin
        w_round_up = r_s1_a[i-1];
      end
    end
  end

`ifdef NOD_OVF_EN
  always_comb begin
    w_idx = r_s1_lead;
    if (w_round_up) begin
      // p = W-1 rounds to W, which fits IW bits by construction.
      w_idx = r_s1_lead + IW'(1);
    end
    if (w_s1_zero) begin
      w_idx = '0;
    end
  end
`else
  logic w_at_top;

  assign w_at_top = (r_s1_lead == IW'(W-1));

  always_comb begin
    w_idx = r_s1_lead;
    // Rounding past bit W-1 saturates at 2^(W-1); residual then goes positive.
    if (w_round_up && !w_at_top) begin
      w_idx = r_s1_lead + IW'(1);
    end
    if (w_s1_zero) begin
      w_idx = '0;
    end
  end
`endif

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i <= W; i++) begin
      if (w_idx == IW'(i)) begin
        w_onehot[i] = 1'b1;
      end
    end
    if (w_s1_zero) begin
      w_onehot = '0;
    end
`ifndef NOD_OVF_EN
    w_onehot[W] = 1'b0;
`endif
  end

  // Both operands zero-extended to W+2 bits; the difference lies within
  // [-2^(W-1), 2^(W-1)) so the two's complement result is always exact.
  assign w_res = {2'b00, r_s1_a} - {1'b0, w_onehot};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_onehot <= '0;
      r_s2_idx    <= '0;
      r_s2_res    <= '0;
      r_s2_zero   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_onehot <= w_onehot;
        r_s2_idx    <= w_idx;
        r_s2_res    <= w_res;
        r_s2_zero   <= w_s1_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from S2 so they hold steady while stalled.
  // ---------------------------------------------------------------------------
  assign out_valid  = r_s2_valid;
  assign out_onehot = r_s2_onehot;
  assign out_idx    = r_s2_idx;
  assign out_res    = r_s2_res;
  assign out_zero   = r_s2_zero;

endmodule
